// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared types for the traffic light controller and its sensor front end.
// Light colours come from the controller; channel states belong to the conditioner.
package light_package;

    typedef enum logic [1:0] {
        red,
        yellow,
        green
    } colors;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_PEND,
        S_SERVE
    } chan_state_t;

    localparam int CNT_W = $clog2(15 + 1);

endpackage

// File: rtl/traffic_sensor_conditioner_channel.sv
// One detector channel: debounce, latch the request, and hold it
// until the matching light has been green for a minimum time.
module sensor_channel
    import light_package::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int SERVE    = 2
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  raw_i,
    input  colors light_i,
    output logic  sensor_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] SRV_MIN = CNT_W'(SERVE);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic             is_green;

    assign is_green = (light_i == green);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (raw_i) begin
                    state_d = S_ARM;
                    dcnt_d  = CNT_W'(1);
                end else begin
                    dcnt_d  = '0;
                end
            end
            S_ARM: begin
                if (!raw_i) begin
                    state_d = S_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = S_PEND;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d  = dcnt_q + CNT_W'(1);
                end
            end
            S_PEND: begin
                if (is_green) begin
                    state_d = S_SERVE;
                    gcnt_d  = CNT_W'(1);
                end
            end
            S_SERVE: begin
                if (is_green) begin
                    if (gcnt_q >= SRV_MIN && !raw_i) begin
                        state_d = S_IDLE;
                        gcnt_d  = '0;
                    end else if (gcnt_q >= SRV_MIN) begin
                        gcnt_d  = SRV_MIN;
                    end else begin
                        gcnt_d  = gcnt_q + CNT_W'(1);
                    end
                end else begin
                    // A vehicle still present when the green ends re-queues.
                    state_d = raw_i ? S_PEND : S_IDLE;
                    gcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                dcnt_d  = '0;
                gcnt_d  = '0;
            end
        endcase
    end

    assign sensor_o = (state_q == S_PEND) || (state_q == S_SERVE);

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the five raw vehicle detectors into controller requests.
// Channels are independent copies of sensor_channel.
module traffic_sensor_conditioner
    import light_package::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int SERVE    = 2
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  e_str_raw,
    input  logic  w_str_raw,
    input  logic  e_left_raw,
    input  logic  w_left_raw,
    input  logic  ns_raw,
    input  colors e_str_light,
    input  colors w_str_light,
    input  colors e_left_light,
    input  colors w_left_light,
    input  colors ns_light,
    output logic  e_str_sensor,
    output logic  w_str_sensor,
    output logic  e_left_sensor,
    output logic  w_left_sensor,
    output logic  ns_sensor
);

    sensor_channel #(.DEBOUNCE(DEBOUNCE), .SERVE(SERVE)) u_e_str (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (e_str_raw),
        .light_i  (e_str_light),
        .sensor_o (e_str_sensor)
    );

    sensor_channel #(.DEBOUNCE(DEBOUNCE), .SERVE(SERVE)) u_w_str (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (w_str_raw),
        .light_i  (w_str_light),
        .sensor_o (w_str_sensor)
    );

    sensor_channel #(.DEBOUNCE(DEBOUNCE), .SERVE(SERVE)) u_e_left (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (e_left_raw),
        .light_i  (e_left_light),
        .sensor_o (e_left_sensor)
    );

    sensor_channel #(.DEBOUNCE(DEBOUNCE), .SERVE(SERVE)) u_w_left (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (w_left_raw),
        .light_i  (w_left_light),
        .sensor_o (w_left_sensor)
    );

    sensor_channel #(.DEBOUNCE(DEBOUNCE), .SERVE(SERVE)) u_ns (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (ns_raw),
        .light_i  (ns_light),
        .sensor_o (ns_sensor)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed stimulus, a
// run-length request model checked every cycle, plus literal checks.
module tb_traffic_sensor_conditioner;
    import light_package::*;

    localparam int DEBOUNCE = 3;
    localparam int SERVE    = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] raw;
    colors      lt [5];
    logic [4:0] sen;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_sensor_conditioner #(.DEBOUNCE(DEBOUNCE), .SERVE(SERVE)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .e_str_raw     (raw[0]),
        .w_str_raw     (raw[1]),
        .e_left_raw    (raw[2]),
        .w_left_raw    (raw[3]),
        .ns_raw        (raw[4]),
        .e_str_light   (lt[0]),
        .w_str_light   (lt[1]),
        .e_left_light  (lt[2]),
        .w_left_light  (lt[3]),
        .ns_light      (lt[4]),
        .e_str_sensor  (sen[0]),
        .w_str_sensor  (sen[1]),
        .e_left_sensor (sen[2]),
        .w_left_sensor (sen[3]),
        .ns_sensor     (sen[4])
    );

    // Model: a request is raised by DEBOUNCE consecutive high samples,
    // and dropped by a long enough green run with no vehicle present.
    bit req     [5];
    int hi_run  [5];
    int grn_run [5];
    bit started = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            started = 1;
            for (int c = 0; c < 5; c++) begin
                req[c] = 0; hi_run[c] = 0; grn_run[c] = 0;
            end
        end else begin
            for (int c = 0; c < 5; c++) begin
                if (!req[c]) begin
                    hi_run[c] = raw[c] ? hi_run[c] + 1 : 0;
                    if (hi_run[c] == DEBOUNCE) begin
                        req[c] = 1; hi_run[c] = 0;
                    end
                end else if (lt[c] == green) begin
                    if (grn_run[c] >= SERVE && !raw[c]) begin
                        req[c] = 0; grn_run[c] = 0;
                    end else begin
                        grn_run[c] = grn_run[c] + 1;
                    end
                end else begin
                    if (grn_run[c] > 0 && !raw[c]) req[c] = 0;
                    grn_run[c] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [4:0] act,
                         input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [4:0] m;
            for (int c = 0; c < 5; c++) m[c] = req[c];
            check("model", sen, m);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lights(input colors c);
        for (int i = 0; i < 5; i++) lt[i] = c;
    endtask

    initial begin
        reset_n = 1'b0;
        raw = '0;
        lights(red);
        cyc(2);
        check("reset", sen, 5'b00000);
        reset_n = 1'b1;

        raw[0] = 1'b1;
        cyc(1); check("glitch1", {4'b0, sen[0]}, 5'b0);
        cyc(1); check("glitch2", {4'b0, sen[0]}, 5'b0);
        raw[0] = 1'b0;
        cyc(3); check("glitch_after", {4'b0, sen[0]}, 5'b0);

        raw[3] = 1'b1;
        cyc(2); check("latch_pre", {4'b0, sen[3]}, 5'b0);
        cyc(1); check("latch_rise", {4'b0, sen[3]}, 5'b1);
        raw[3] = 1'b0;
        cyc(22); check("latch_hold", {4'b0, sen[3]}, 5'b1);

        raw[4] = 1'b1;
        cyc(3);
        raw[4] = 1'b0;
        check("ns_pend", {4'b0, sen[4]}, 5'b1);
        lt[4] = green;
        cyc(1); check("ns_g1", {4'b0, sen[4]}, 5'b1);
        cyc(1); check("ns_g2", {4'b0, sen[4]}, 5'b1);
        cyc(1); check("ns_g3", {4'b0, sen[4]}, 5'b0);
        lt[4] = red;

        raw[2] = 1'b1;
        cyc(3);
        lt[2] = green;
        cyc(1); check("el_serve", {4'b0, sen[2]}, 5'b1);
        lt[2] = yellow;
        cyc(1); check("el_yellow", {4'b0, sen[2]}, 5'b1);
        lt[2] = red;
        raw[2] = 1'b0;
        cyc(5); check("el_red", {4'b0, sen[2]}, 5'b1);
        lt[2] = green;
        cyc(2); check("el_g2", {4'b0, sen[2]}, 5'b1);
        cyc(1); check("el_g3", {4'b0, sen[2]}, 5'b0);
        lt[2] = red;

        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        check("reset2", sen, 5'b00000);
        raw = 5'b11111;
        cyc(3);
        raw = '0;
        check("all_pend", sen, 5'b11111);
        lt[4] = green;
        cyc(3); check("indep", sen, 5'b01111);
        lt[4] = red;

        raw[4] = 1'b1;
        cyc(2);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        check("reset_mid", sen, 5'b00000);
        cyc(2); check("fresh2", {4'b0, sen[4]}, 5'b0);
        cyc(1); check("fresh3", {4'b0, sen[4]}, 5'b1);
        raw[4] = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
